// File: rtl/bios_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bios_rom_loader
//  Description : Boot-time loader for the 386 system ROM window. After reset
//                it reads a BIOS image from SPI NOR flash (mode 0, opcode
//                0x03) into block RAM, then serves 32-bit reads with one
//                cycle of latency. load_done holds the CPU in reset until the
//                image is in place.
//  Revision    : 1.0 - initial release
// ============================================================================
module bios_rom_loader #(
    parameter logic [23:0] FLASH_OFFSET = 24'h000000,
    parameter int          ROM_WORDS    = 16384,
    parameter int          SCK_DIV      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:2] rom_address,
    input  logic        rom_rd_enable,
    output logic [31:0] rom_rd_data,
    output logic        rom_rd_valid,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        load_done
);

    localparam int          IDX_W    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
    localparam int          DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_OFFSET};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_CMD    = 3'd2,
        S_DATA   = 3'd3,
        S_FINISH = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [31:0]        tx_q, tx_d;
    logic [31:0]        rx_q, rx_d;
    logic               cs_n_q, cs_n_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               load_done_q, load_done_d;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        rd_data_q;

    logic               sck_tick;
    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic [IDX_W-1:0]   rd_idx;

    logic [31:0]        rom_mem [ROM_WORDS];

    // One half SCK period has elapsed when the divider reaches its top value.
    assign sck_tick  = (div_q == DIV_W'(SCK_DIV - 1));
    // Flash bytes arrive MSB-first; the first byte of a word lands in [7:0].
    assign mem_wdata = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
    // Word index wraps modulo ROM_WORDS; one extra bit keeps 16384 representable.
    assign rd_idx    = IDX_W'({1'b0, rom_address} % 15'(ROM_WORDS));

    // Next-state and SPI shifter logic: mosi moves on the falling half, miso
    // is captured on the rising half.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        word_idx_d  = word_idx_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        load_done_d = load_done_q;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d    = S_SETUP;
                cs_n_d     = 1'b0;
                tx_d       = CMD_WORD;
                mosi_d     = CMD_WORD[31];
                div_d      = '0;
                bit_cnt_d  = '0;
                word_idx_d = '0;
            end
            S_SETUP: begin
                if (sck_tick) begin
                    div_d   = '0;
                    state_d = S_CMD;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_CMD, S_DATA: begin
                if (!sck_tick) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[30:0], spi_miso};
                        end
                    end else begin
                        sck_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (state_q == S_CMD) begin
                            tx_d   = {tx_q[30:0], 1'b0};
                            mosi_d = tx_q[30];
                            if (bit_cnt_q == 5'd31) begin
                                state_d = S_DATA;
                                mosi_d  = 1'b0;
                            end
                        end else if (bit_cnt_q == 5'd31) begin
                            mem_we     = 1'b1;
                            word_idx_d = word_idx_q + IDX_W'(1);
                            if (word_idx_q == IDX_W'(ROM_WORDS - 1)) begin
                                state_d = S_FINISH;
                                cs_n_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            S_FINISH: begin
                cs_n_d      = 1'b1;
                sck_d       = 1'b0;
                load_done_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Loader state and SPI output registers; reset releases the flash at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            word_idx_q  <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            word_idx_q  <= word_idx_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            load_done_q <= load_done_d;
        end
    end

    // Image store; only the loader ever writes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            rom_mem[word_idx_q] <= mem_wdata;
        end
    end

    // A request is served only once load_done was already high when sampled.
    always_comb begin
        rd_valid_d = load_done_q & rom_rd_enable;
    end

    // Registered read port; data holds its last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            if (rd_valid_d) begin
                rd_data_q <= rom_mem[rd_idx];
            end
        end
    end

    assign rom_rd_data  = rd_data_q;
    assign rom_rd_valid = rd_valid_q;
    assign spi_cs_n     = cs_n_q;
    assign spi_sck      = sck_q;
    assign spi_mosi     = mosi_q;
    assign load_done    = load_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bios_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bios_rom_loader
//  Description : Bench for bios_rom_loader. Two instances (SCK_DIV=2 with 128
//                words, SCK_DIV=5 with 8 words) each talk to a behavioural
//                SPI flash; reads are scored against a queue of expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bios_rom_loader;

    localparam logic [23:0] OFFS = 24'h010000;
    localparam int WORDS_A = 128;
    localparam int WORDS_B = 8;
    localparam int LOAD_A  = 2 + 4 * (32 + 32 * WORDS_A) + 2;
    localparam int LOAD_B  = 5 + 10 * (32 + 32 * WORDS_B) + 2;

    logic        clk;
    logic        rst;
    logic [15:2] addr_a, addr_b;
    logic        en_a, en_b;
    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic        cs_n_a, cs_n_b, sck_a, sck_b, mosi_a, mosi_b;
    logic        miso_a, miso_b;
    logic        done_a, done_b;
    logic [7:0]  seed;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];

    int          fa_bits = 0, fb_bits = 0;
    int          fa_csfall = 0, fb_csfall = 0;
    logic [31:0] fa_cmd = '0, fb_cmd = '0;

    bios_rom_loader #(.FLASH_OFFSET(OFFS), .ROM_WORDS(WORDS_A), .SCK_DIV(2)) u_dut_a (
        .clk(clk), .rst(rst), .rom_address(addr_a), .rom_rd_enable(en_a),
        .rom_rd_data(data_a), .rom_rd_valid(valid_a), .spi_cs_n(cs_n_a),
        .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .load_done(done_a)
    );

    bios_rom_loader #(.FLASH_OFFSET(OFFS), .ROM_WORDS(WORDS_B), .SCK_DIV(5)) u_dut_b (
        .clk(clk), .rst(rst), .rom_address(addr_b), .rom_rd_enable(en_b),
        .rom_rd_data(data_b), .rom_rd_valid(valid_b), .spi_cs_n(cs_n_b),
        .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b), .load_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash image byte k relative to the offset.
    function automatic logic [7:0] fbyte(input int k);
        if (k < 4) return 8'(8'h11 * (k + 1));
        return 8'(k * 37 + 13) ^ seed;
    endfunction

    function automatic logic fbit(input int k);
        logic [7:0] b;
        b = fbyte(k / 8);
        return b[7 - (k % 8)];
    endfunction

    function automatic logic [31:0] exp_word(input int i);
        return {fbyte(4*i+3), fbyte(4*i+2), fbyte(4*i+1), fbyte(4*i)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Flash models: capture the command, then shift data out on falling SCK.
    always @(negedge cs_n_a) begin fa_bits = 0; fa_csfall++; end
    always @(posedge sck_a) begin
        if (fa_bits < 32) fa_cmd = {fa_cmd[30:0], mosi_a};
        fa_bits++;
    end
    always @(negedge sck_a) if (fa_bits >= 32) miso_a = fbit(fa_bits - 32);

    always @(negedge cs_n_b) begin fb_bits = 0; fb_csfall++; end
    always @(posedge sck_b) begin
        if (fb_bits < 32) fb_cmd = {fb_cmd[30:0], mosi_b};
        fb_bits++;
    end
    always @(negedge sck_b) if (fb_bits >= 32) miso_b = fbit(fb_bits - 32);

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (valid_a) begin
            if (q_a.size() > 0) check_eq("a_rd_data", data_a, q_a.pop_front());
            else                check_eq("a_valid_unexpected", {31'b0, valid_a}, 32'd0);
        end
        if (valid_b) begin
            if (q_b.size() > 0) check_eq("b_rd_data", data_b, q_b.pop_front());
            else                check_eq("b_valid_unexpected", {31'b0, valid_b}, 32'd0);
        end
    end

    task automatic read_a(input logic [13:0] a, input logic [31:0] expv);
        @(negedge clk);
        addr_a = a;
        en_a   = 1'b1;
        q_a.push_back(expv);
    endtask

    task automatic read_b(input logic [13:0] a, input logic [31:0] expv);
        @(negedge clk);
        addr_b = a;
        en_b   = 1'b1;
        q_b.push_back(expv);
    endtask

    task automatic single_read_a(input string tag, input logic [13:0] a, input logic [31:0] expv);
        read_a(a, expv);
        @(negedge clk);
        en_a = 1'b0;
        check_eq({tag, "_valid_1cyc"}, {31'b0, valid_a}, 32'd1);
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, {31'b0, valid_a}, 32'd0);
    endtask

    task automatic wait_load_a(input string tag);
        int cnt;
        cnt = 0;
        while (cnt < LOAD_A + 200) begin
            @(negedge clk);
            cnt++;
            if (done_a) break;
        end
        check_eq(tag, cnt, LOAD_A);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp0;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; addr_a = '0; addr_b = '0;
        seed = 8'h00; miso_a = 1'b0; miso_b = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_cs_n",  {31'b0, cs_n_a},  32'd1);
        check_eq("rst_sck",   {31'b0, sck_a},   32'd0);
        check_eq("rst_mosi",  {31'b0, mosi_a},  32'd0);
        check_eq("rst_done",  {31'b0, done_a},  32'd0);
        check_eq("rst_valid", {31'b0, valid_a}, 32'd0);
        check_eq("rst_data",  data_a,           32'd0);

        // Request held from reset release: must stall until after load_done.
        en_a = 1'b1;
        rst  = 1'b0;
        fork
            begin : a_load
                wait_load_a("a_load_cycles");
                if (done_a) q_a.push_back(exp_word(0));
                @(negedge clk);
                check_eq("a_stall_valid", {31'b0, valid_a}, 32'd1);
                en_a = 1'b0;
            end
            begin : b_load
                int cnt;
                cnt = 0;
                while (cnt < LOAD_B + 200) begin
                    @(negedge clk);
                    cnt++;
                    if (done_b) break;
                end
                check_eq("b_load_cycles", cnt, LOAD_B);
            end
            begin : b_phase
                longint t0, t1, t2;
                @(posedge sck_b); t0 = $time;
                @(negedge sck_b); t1 = $time;
                @(posedge sck_b); t2 = $time;
                check_eq("b_sck_high", 32'((t1 - t0) / 10), 32'd5);
                check_eq("b_sck_low",  32'((t2 - t1) / 10), 32'd5);
            end
        join

        check_eq("a_cmd", fa_cmd, {8'h03, OFFS});
        check_eq("a_cs_falls", fa_csfall, 1);
        check_eq("b_cmd", fb_cmd, {8'h03, OFFS});
        check_eq("b_cs_falls", fb_csfall, 1);

        exp0 = 32'h44332211;
        single_read_a("a_word0", 14'h0000, exp0);

        // Full sweep followed by streaming across the top and wrap to word 0.
        for (int i = 0; i < WORDS_A; i++) read_a(14'(i), exp_word(i));
        read_a(14'h3FFE, exp_word(WORDS_A - 2));
        read_a(14'h3FFF, exp_word(WORDS_A - 1));
        read_a(14'h0000, exp0);
        @(negedge clk); en_a = 1'b0;

        for (int i = 0; i < WORDS_B; i++) read_b(14'(i), exp_word(i));
        read_b(14'h3FFF, exp_word(WORDS_B - 1));
        @(negedge clk); en_b = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("a_queue_empty", q_a.size(), 0);
        check_eq("b_queue_empty", q_b.size(), 0);

        // Restart a load, then reset it in the middle of word 100.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        begin : wait_w100
            int cnt;
            cnt = 0;
            while (fa_bits < 32 + 100 * 32 + 10 && cnt < 20000) begin
                @(negedge clk);
                cnt++;
            end
            check_eq("a_reach_w100", {31'b0, fa_bits >= 32 + 100 * 32 + 10}, 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        check_eq("a_midrst_cs_n", {31'b0, cs_n_a}, 32'd1);
        check_eq("a_midrst_done", {31'b0, done_a}, 32'd0);
        seed = 8'hA5;
        @(negedge clk);
        rst = 1'b0;
        wait_load_a("a_reload_cycles");
        check_eq("a_cmd_reload", fa_cmd, {8'h03, OFFS});
        check_eq("a_cs_falls_reload", fa_csfall, 3);

        single_read_a("a_word100", 14'd100, exp_word(100));
        for (int i = 0; i < WORDS_A; i++) read_a(14'(i), exp_word(i));
        @(negedge clk); en_a = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("a_queue_empty_reload", q_a.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bios_rom_loader.md
# bios_rom_loader

Boot-time BIOS image loader and read-only memory for the 386 system ROM window. It sits directly downstream of the bus master's ROM port (`rom_address`, `rom_rd_enable`, `rom_rd_data`, `rom_rd_valid`). After reset, it copies a 64 KB image from an external SPI NOR flash into on-chip block RAM. It then serves 32-bit reads with one-cycle latency, and `load_done` gates the CPU reset.

## Interface
- `FLASH_OFFSET`, default 24'h000000: flash byte address of the image's first byte.
- `ROM_WORDS`, default 16384: number of 32-bit words loaded and stored; the index is `rom_address[15:2]`.
- `SCK_DIV`, default 2: `spi_sck` half-period in `clk` cycles; legal range is 1 or more.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `rom_address` in [15:2]: word address from the bus master.
- `rom_rd_enable` in 1: read request; level-sensitive.
- `rom_rd_data` out 32: read data.
- `rom_rd_valid` out 1: `rom_rd_data` is valid for the address sampled on the previous cycle.
- `spi_cs_n` out 1: flash chip select, active low.
- `spi_sck` out 1: SPI clock, mode 0.
- `spi_mosi` out 1: serial data to the flash.
- `spi_miso` in 1: serial data from the flash.
- `load_done` out 1: image fully loaded; stays high until the next reset.

## Operation
- **Reset values:** `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `load_done`=0, `rom_rd_valid`=0, `rom_rd_data`=0. Reset also clears the state register, bit counter and word index.
- **States:** IDLE → SETUP → CMD → DATA → FINISH → DONE.
- **IDLE:** entered from reset. Moves to SETUP on the first clock after `rst` deasserts.
- **SETUP:** drives `spi_cs_n`=0 and presents the first MOSI bit. Holds for `SCK_DIV` cycles, then moves to CMD.
- **CMD:** shifts out 32 bits, MSB first. The first 8 bits are the read opcode 0x03; the last 24 bits are `FLASH_OFFSET`. Moves to DATA after the 32nd falling edge.
- **DATA:** shifts in `32*ROM_WORDS` bits, MSB first within each byte.
  - Bytes are packed little-endian: the first byte of each group of four goes to [7:0], the fourth to [31:24].
  - Each completed word is written to BRAM[`word_idx`], then `word_idx` increments.
  - After word `ROM_WORDS-1` is written, the state moves to FINISH.
- **FINISH:** drives `spi_cs_n`=1 and `spi_sck`=0. Sets `load_done`=1 on the next cycle and moves to DONE.
- **DONE:** terminal state. No further SPI activity occurs.
- **SPI bit timing (mode 0):**
  - `spi_sck` idles low.
  - `spi_mosi` changes only while `spi_sck` is low.
  - `spi_miso` is sampled on the clk edge that raises `spi_sck`.
  - Each bit lasts `2*SCK_DIV` clk cycles.
- **Read port:**
  - While `load_done`=0, `rom_rd_valid`=0 regardless of `rom_rd_enable`; the bus master stalls.
  - While `load_done`=1 and `rom_rd_enable`=1, the block registers `rom_rd_data`=BRAM[`rom_address`] and sets `rom_rd_valid`=1 on the next cycle.
  - `rom_rd_enable`=0 drives `rom_rd_valid`=0 on the next cycle; `rom_rd_data` holds its last value.
- **Address range:** addresses at or above `ROM_WORDS` wrap modulo `ROM_WORDS`. At the default, all 14 bits are used, so no wrap occurs.
- **Writes:** the BRAM is not writable from the bus; only the loader writes it.
- **Simultaneous events:** a read request on the same cycle `load_done` rises is not served. Valid first asserts one cycle after a request sampled with `load_done`=1.
- **Reset mid-load:** `spi_cs_n` goes high asynchronously and the partial image is discarded. The load restarts from IDLE; BRAM contents are overwritten by the new load.

## Timing
- **Load duration:** (`SCK_DIV` setup) + 2·`SCK_DIV`·(32 + 32·`ROM_WORDS`) + 2 cycles from reset release to `load_done`. At the defaults this is 2 + 4·524320 + 2 = 2,097,284 cycles.
- **Read latency:** 1 cycle. Back-to-back reads at one address per cycle are supported while `rom_rd_enable` stays high.
- **Output registers:** all outputs come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- **Command phase:** with the flash model holding `FLASH_OFFSET`=24'h010000, release reset → `spi_cs_n` falls once, then MOSI carries 0x03, 0x01, 0x00, 0x00 over the first 32 rising edges of `spi_sck`.
- **Load and byte order:** flash bytes 0x11, 0x22, 0x33, 0x44 at the offset → after `load_done`, a read of `rom_address`=0 returns 32'h44332211 with `rom_rd_valid`=1 exactly one cycle after `rom_rd_enable` rises.
- **Stall before load:** hold `rom_rd_enable`=1 from reset release → `rom_rd_valid` stays 0 until the cycle after `load_done`, then goes to 1 with the correct data.
- **Streaming reads:** after load, hold `rom_rd_enable` high and step `rom_address` through 14'h3FFE, 14'h3FFF, 14'h0000 → data appears for each address one cycle later, including the last word and the wrap back to word 0.
- **Reset mid-load:** assert `rst` during word 100 → `spi_cs_n`=1 immediately and `load_done`=0. After release, a full reload completes in exactly the documented cycle count, and word 100 reads correctly.
- **Slow SCK:** with `SCK_DIV`=5, each `spi_sck` high and low phase is 5 cycles → load completes and data matches the flash model.
